// File: rtl/dmem_server_pkg.sv
// Shared load/store port types between the core and dmem_server.
// dmem_ prefixed state literals keep clear of the core's own FSM names.
package dmem_server_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_server_byte_lane.sv
// Byte lane merge for byte stores and zero-extended lane extract for byte loads.
// Purely combinational; no handshake.
module dmem_byte_lane (
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] merged_o,
  output logic [31:0] extract_o
);

  always_comb begin
    merged_o  = word_i;
    extract_o = '0;
    merged_o[{lane_i, 3'b000} +: 8]  = byte_i;
    extract_o[7:0]                   = word_i[{lane_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/dmem_server.sv
// Single-outstanding data memory: accept in IDLE, latency_p cycles in WAIT, response held in RESP.
// Request yumi only in IDLE; response held until the core's yumi.
module dmem_server
  import dmem_server_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o
);

  localparam int         depth_lp    = 2 ** addr_width_p;
  localparam int         lat_m1_lp   = (latency_p > 0) ? latency_p - 1 : 0;
  localparam logic [3:0] lat_load_lp = 4'(lat_m1_lp);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] resp_q, resp_d;

  logic [31:0] mem_q [depth_lp];

  logic [addr_width_p-1:0] idx;
  logic [1:0]              lane;
  logic [31:0]             cur_word;
  logic [31:0]             merged_word;
  logic [31:0]             lane_word;
  logic                    mem_we;
  logic [31:0]             mem_wdata;
  logic                    unused_addr_hi;

  assign idx            = addr_i[2 +: addr_width_p];
  assign lane           = addr_i[1:0];
  assign cur_word       = mem_q[idx];
  assign unused_addr_hi = ^addr_i[31:2+addr_width_p];

  dmem_byte_lane u_byte_lane (
    .word_i    (cur_word),
    .lane_i    (lane),
    .byte_i    (to_mem_i.write_data[7:0]),
    .merged_o  (merged_word),
    .extract_o (lane_word)
  );

  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    resp_d               = resp_q;
    mem_we               = 1'b0;
    mem_wdata            = to_mem_i.write_data;
    from_mem_o           = '0;
    from_mem_o.read_data = resp_q;

    unique case (state_q)
      DMEM_IDLE: begin
        // Gated by reset so a valid seen during the reset cycle is not acknowledged.
        from_mem_o.yumi = to_mem_i.valid & reset;
        if (to_mem_i.valid && reset) begin
          mem_we    = to_mem_i.wen;
          mem_wdata = to_mem_i.byte_not_word ? merged_word : to_mem_i.write_data;
          if (to_mem_i.wen) begin
            resp_d = '0;
          end else begin
            resp_d = to_mem_i.byte_not_word ? lane_word : cur_word;
          end
          if (latency_p > 0) begin
            state_d = DMEM_WAIT;
            cnt_d   = lat_load_lp;
          end else begin
            state_d = DMEM_RESP;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMEM_RESP: begin
        from_mem_o.valid = reset;
        if (to_mem_i.yumi) begin
          state_d = DMEM_IDLE;
        end
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // Array contents survive reset; a store commits on its accept edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_server.sv
// Directed + random checks of dmem_server at latency 2 and latency 0 against a word-array model.
module tb_dmem_server;
  import dmem_server_pkg::*;

  logic        clk;
  logic        reset;
  mem_in_s     tin   [2];
  logic [31:0] taddr [2];
  mem_out_s    tout  [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_acc [2];

  logic [31:0] mref [2][1024];

  dmem_server #(.addr_width_p(10), .latency_p(2)) dut (
    .clk(clk), .reset(reset), .to_mem_i(tin[0]), .addr_i(taddr[0]), .from_mem_o(tout[0])
  );

  dmem_server #(.addr_width_p(10), .latency_p(0)) dut0 (
    .clk(clk), .reset(reset), .to_mem_i(tin[1]), .addr_i(taddr[1]), .from_mem_o(tout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: word-addressed array, index wraps modulo depth, byte lanes by address mod 4.
  function automatic logic [31:0] model(input int d, input bit wen, input bit bnw,
                                        input logic [31:0] addr, input logic [31:0] wd);
    int idx;
    int lane;
    logic [31:0] w;
    idx  = int'((addr >> 2) % 1024);
    lane = int'(addr % 4);
    w    = mref[d][idx];
    if (wen) begin
      if (bnw) w[lane*8 +: 8] = wd[7:0];
      else     w = wd;
      mref[d][idx] = w;
      return 32'h0;
    end
    if (bnw) return (w >> (8 * lane)) & 32'hFF;
    return w;
  endfunction

  // Called at posedge+1; returns at posedge+2 of the cycle after the response is consumed.
  task automatic txn(input int d, input bit wen, input bit bnw, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, output logic [31:0] rd);
    int lat;
    int waited;
    logic [31:0] exp;
    logic [31:0] held;
    lat = (d == 0) ? 2 : 0;
    exp = model(d, wen, bnw, addr, wdata);
    tin[d].valid         = 1'b1;
    tin[d].wen           = wen;
    tin[d].byte_not_word = bnw;
    tin[d].write_data    = wdata;
    tin[d].yumi          = 1'b0;
    taddr[d]             = addr;
    last_acc[d]          = cyc;
    #1;
    chk("accept_yumi", {31'b0, tout[d].yumi}, 32'd1);
    chk("accept_no_valid", {31'b0, tout[d].valid}, 32'd0);
    @(posedge clk); #1;
    tin[d].valid = 1'b0;
    waited = 0;
    while (tout[d].valid !== 1'b1 && waited < 40) begin
      chk("wait_yumi_low", {31'b0, tout[d].yumi}, 32'd0);
      @(posedge clk); #1;
      waited++;
    end
    chk("latency", waited, lat);
    chk("rdata", tout[d].read_data, exp);
    held = tout[d].read_data;
    // Back-pressure: offer a conflicting store while the response waits.
    repeat (hold) begin
      tin[d].valid         = 1'b1;
      tin[d].wen           = 1'b1;
      tin[d].byte_not_word = 1'b0;
      tin[d].write_data    = 32'hFFFF_FFFF;
      taddr[d]             = 32'h40;
      #1;
      chk("hold_yumi_low", {31'b0, tout[d].yumi}, 32'd0);
      chk("hold_valid", {31'b0, tout[d].valid}, 32'd1);
      chk("hold_rdata", tout[d].read_data, held);
      @(posedge clk); #1;
    end
    tin[d].yumi = 1'b1;
    #1;
    chk("resp_yumi_low", {31'b0, tout[d].yumi}, 32'd0);
    chk("resp_valid", {31'b0, tout[d].valid}, 32'd1);
    @(posedge clk); #1;
    tin[d].yumi  = 1'b0;
    tin[d].valid = 1'b0;
    #1;
    chk("post_valid_low", {31'b0, tout[d].valid}, 32'd0);
    rd = held;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] v;
    int a;
    for (int d = 0; d < 2; d++) begin
      tin[d]   = '0;
      taddr[d] = '0;
      tin[d].valid = 1'b1;
      last_acc[d] = 0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", {31'b0, tout[d].valid}, 32'd0);
      chk("rst_yumi", {31'b0, tout[d].yumi}, 32'd0);
      chk("rst_rdata", tout[d].read_data, 32'd0);
    end
    tin[0].valid = 1'b0;
    tin[1].valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 17; w++)
        txn(d, 1'b1, 1'b0, 32'(w * 4), $urandom, 0, rd);

    // Word store/load at latency 2.
    txn(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 0, rd);
    chk("st_word_resp", rd, 32'h0);
    txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 0, rd);
    chk("ld_word", rd, 32'hDEADBEEF);

    // Byte store/load.
    txn(0, 1'b1, 1'b0, 32'h10, 32'h11223344, 0, rd);
    txn(0, 1'b1, 1'b1, 32'h12, 32'h5566_77AA, 0, rd);
    txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 0, rd);
    chk("byte_merge", rd, 32'h11AA3344);
    txn(0, 1'b0, 1'b1, 32'h13, 32'h0, 0, rd);
    chk("byte_load", rd, 32'h00000011);

    // Back-pressure: the offered store to 0x40 must never be taken.
    txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 5, rd);
    chk("bp_rdata", rd, 32'hDEADBEEF);
    txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 0, rd);
    chk("bp_no_accept", rd, 32'hDEADBEEF);

    // Address wrap above addr_width_p.
    v = $urandom;
    txn(0, 1'b1, 1'b0, 32'h0000_1004, v, 0, rd);
    txn(0, 1'b0, 1'b0, 32'h4, 32'h0, 0, rd);
    chk("wrap", rd, v);

    // Reset during WAIT: response dropped, store kept.
    void'(model(0, 1'b1, 1'b0, 32'h8, 32'h5A5A5A5A));
    tin[0].valid = 1'b1; tin[0].wen = 1'b1; tin[0].byte_not_word = 1'b0;
    tin[0].write_data = 32'h5A5A5A5A; taddr[0] = 32'h8;
    #1;
    chk("rw_accept", {31'b0, tout[0].yumi}, 32'd1);
    @(posedge clk); #1;
    tin[0].valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rw_valid_in_rst", {31'b0, tout[0].valid}, 32'd0);
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rw_valid_after", {31'b0, tout[0].valid}, 32'd0);
    end
    txn(0, 1'b0, 1'b0, 32'h8, 32'h0, 0, rd);
    chk("rw_kept", rd, 32'h5A5A5A5A);

    // Latency 0 back-to-back loads in 2-cycle slots.
    txn(1, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 0, rd);
    chk("l0_st_resp", rd, 32'h0);
    txn(1, 1'b0, 1'b0, 32'h20, 32'h0, 0, rd);
    a = last_acc[1];
    txn(1, 1'b0, 1'b0, 32'h20, 32'h0, 0, rd);
    chk("l0_slot", 32'(last_acc[1] - a), 32'd2);
    chk("l0_ld", rd, 32'hCAFEF00D);

    // Random traffic confined to initialised words, with random upper bits.
    for (int i = 0; i < 60; i++) begin
      int d;
      logic [31:0] addr;
      d    = i % 2;
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      txn(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
          $urandom_range(0, 2), rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_server.md
# dmem_server

Multi-cycle data memory that serves the core's load/store port. Accepts one request at a time over the valid/yumi handshake, performs word or byte accesses on a synchronous word array, and returns a response after a programmable latency. Sits directly downstream of the core's memory interface; it is the consumer of the core's mem_in_s and the producer of its mem_out_s.

## Interface
- addr_width_p, 10: log2 of array depth in 32-bit words
- latency_p, 2: cycles spent in WAIT between accept and response; 0 to 15
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low
- to_mem_i  in  mem_in_s  request: write_data, valid, wen, byte_not_word, and yumi (response consumed)
- addr_i  in  32  byte address, sampled at accept
- from_mem_o  out  mem_out_s  response: read_data, valid (response ready), yumi (request accepted)

## Operation
- States: IDLE, WAIT, RESP (dmem_state_e).
- IDLE: from_mem_o.yumi = to_mem_i.valid, combinational. Accept when both high; latch addr_i, wen, byte_not_word, write_data. Next state WAIT if latency_p>0 (counter loaded with latency_p-1), else RESP.
- WAIT: counter decrements each cycle; at 0 go RESP. yumi low; to_mem_i.valid ignored.
- RESP: from_mem_o.valid = 1, read_data held stable. When to_mem_i.yumi = 1 go IDLE in the next cycle; no new accept during RESP.
- Addressing: word index = addr_i[2 +: addr_width_p]; byte lane = addr_i[1:0]; upper bits ignored (wrap). Word access ignores addr_i[1:0].
- Store word: array[idx] <= write_data on accept edge. Store byte: only lane addr_i[1:0] replaced with write_data[7:0]; other lanes kept.
- Load word: read_data = array[idx]. Load byte: read_data = {24'b0, selected lane}, zero-extended.
- Store response: read_data = 32'b0; valid still asserted so the core can retire.
- Array read happens at accept; the value is registered into the response register, so a store followed by a load to the same word returns the new value.

## Timing
- Reset: state IDLE, counter 0, response register 0; from_mem_o.valid = 0, from_mem_o.yumi = 0 (valid_i ignored in reset cycle), read_data = 0. Array contents not cleared.
- Accept cycle T: with latency_p = L, valid rises in cycle T+1+L. The minimum round trip at L=0 is accept T, valid at T+1, yumi from core at T+1, IDLE at T+2, next accept T+2.
- Response is held indefinitely until to_mem_i.yumi; read_data must not change while valid.
- to_mem_i.yumi outside RESP is ignored.
- Reset mid-operation in WAIT or RESP: return to IDLE and drop the pending response. A store already committed at accept stays written.
- to_mem_i.valid dropping after accept has no effect.

## Structure
- The shared definitions package holds mem_in_s, mem_out_s, and the new dmem_state_e {IDLE, WAIT, RESP} with a dmem_ prefix on the enum literals, to avoid clashing with core state names.
- One sub-module, dmem_byte_lane: combinational lane merge for byte store and lane extract/zero-extend for byte load.
- The array is a plain reg array inside dmem_server, 2**addr_width_p words.

## Test plan
- Word store then load, L=2: store 32'hDEADBEEF at addr 0x40, then load 0x40. Yumi on accept cycle; valid 3 cycles later; load read_data = 32'hDEADBEEF.
- Byte store/load: word 0x10 = 32'h11223344. Store byte 8'hAA at 0x12 → word 32'h11AA3344. Byte load from 0x13 → 32'h00000011.
- Back-pressure: hold to_mem_i.yumi low for 5 cycles in RESP. Valid and read_data stay stable; a new valid request is not accepted until the cycle after yumi.
- L=0 back-to-back: two loads with core-style combinational yumi complete in consecutive 2-cycle slots. Store response read_data = 0.
- Wrap: a store to addr 32'h0000_1004 with addr_width_p=10 hits word 1; a load of addr 0x4 returns the stored value.
- Reset in WAIT: assert reset during WAIT after a store of 32'h5A5A5A5A to 0x8. Valid never rises. After reset, a load of 0x8 returns 32'h5A5A5A5A.
